seg_scan_driver: RTL and testbench
==================================

# seg_scan_driver

Time-multiplexed seven-segment display driver: accepts one 8-bit segment pattern per digit, in the same bit order the state and data display encoders produce, and scans them onto a shared segment bus with one-hot digit enables. It sits between the display encoders and the board's multiplexed display pins. It adds frame-synchronous double buffering, a dead-time blanking guard against ghosting, and per-digit blinking.

## Interface
- NUM_DIGITS, 4: digits scanned, ≥2.
- SCAN_DIV, 1000: clock cycles per digit slot; must exceed BLANK_CYCLES.
- BLANK_CYCLES, 16: dead-time cycles at the start of each slot, ≥1.
- BLINK_FRAMES, 64: frames per blink half-period, ≥1.
- clk  in  1  system clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- scan_en  in  1  1 = scanning runs; 0 = freeze counters, blank outputs.
- digits_in  in  8*NUM_DIGITS  digit i pattern at [8i+7:8i]; bit7 = segment a … bit1 = g, bit0 = dot; 1 = lit.
- load  in  1  one-cycle strobe: capture digits_in.
- blink_mask  in  NUM_DIGITS  bit i set = digit i blinks; sampled live.
- seg_out  out  8  active-high segment bus, same bit order as digits_in.
- dig_sel  out  NUM_DIGITS  one-hot active-high digit enable; all-zero when blank.
- frame_done  out  1  one-cycle pulse at each frame wrap.

## Operation
- State: slot counter c (0..SCAN_DIV-1), digit index idx (0..NUM_DIGITS-1), frame counter f (0..2*BLINK_FRAMES-1), shadow buffer buf, pending flag, display register disp.
- All outputs are registered and coherent with c and idx after the same edge.
- Reset: c=0, idx=0, f=0, pending=0, buf=0, disp=0, seg_out=0, dig_sel=0, frame_done=0.
- Each edge with scan_en=1: c increments. At c=SCAN_DIV-1, c wraps to 0 and idx increments. At idx=NUM_DIGITS-1, idx wraps to 0: this is the frame wrap.
- Slot phases:
  - BLANK (c < BLANK_CYCLES): seg_out=0, dig_sel=0.
  - DRIVE (c ≥ BLANK_CYCLES): dig_sel = 1<<idx; seg_out = disp[idx].
  - During DRIVE, seg_out=0 if blink_mask[idx]=1 and f ≥ BLINK_FRAMES (blink-off phase). dig_sel stays asserted.
- Load, not on a frame-wrap edge: buf <= digits_in, pending <= 1. disp is untouched, so no mid-frame tearing.
- Frame-wrap edge:
  - If load=1: disp <= digits_in directly, buf <= digits_in.
  - Else if pending=1: disp <= buf.
  - pending <= 0 in both cases.
  - f increments mod 2*BLINK_FRAMES.
  - frame_done=1 for that single cycle.
- Multiple loads within one frame: last one wins.
- scan_en=0:
  - c, idx and f hold; next edge drives seg_out=0, dig_sel=0, frame_done=0.
  - load still captures into buf and sets pending.
  - Re-assertion resumes from the held c and idx. The outputs after that first edge reflect the incremented c.
- rst_n low at any time, including mid-slot or mid-frame: immediate asynchronous return to reset values. Any pending load is discarded.

## Timing
- Counting edges from the first rising edge after rst_n deassertion as N=1, with scan_en held at 1: c = N mod SCAN_DIV, idx = floor(N/SCAN_DIV) mod NUM_DIGITS.
- Slot 0 after reset is shortened by one cycle, because the reset state already counts as c=0.
- Dead time: exactly BLANK_CYCLES cycles of all-zero dig_sel before every digit change. There is never more than one dig_sel bit set.
- Load-to-display latency: until the next frame wrap, at most NUM_DIGITS*SCAN_DIV cycles.
- The loaded value is visible from the first DRIVE cycle of digit 0 after the wrap.
- frame_done period: NUM_DIGITS*SCAN_DIV cycles.
- Blink period: 2*BLINK_FRAMES frames, 50% duty.

## Test plan
Parameters for all scenarios: NUM_DIGITS=4, SCAN_DIV=8, BLANK_CYCLES=2, BLINK_FRAMES=2.
- Reset scan:
  - Stimulus: load digits_in=32'hFC_60_DA_F2 at the first frame wrap.
  - Response: from the next frame, dig_sel steps 0001→0010→0100→1000, 6 DRIVE cycles each, separated by 2 all-zero cycles.
  - Response: seg_out shows F2, DA, 60, FC for idx 0..3.
  - Response: frame_done pulses every 32 cycles.
- Mid-frame load:
  - Stimulus: load 32'h11111111 while idx=1.
  - Response: digits 2 and 3 still show the old patterns; 11 appears first on digit 0 after the wrap.
  - Response: pending clears at the wrap.
- Load on the wrap edge:
  - Stimulus: assert load in the same cycle as the frame wrap.
  - Response: disp takes digits_in immediately; pending=0 afterwards.
- Blink:
  - Stimulus: blink_mask=4'b0100.
  - Response: digit 2 shows seg_out=0 with dig_sel=0100 asserted during frames where f=2,3, and shows its pattern during f=0,1.
  - Response: all other digits are unaffected.
- scan_en:
  - Stimulus: drop scan_en for 5 cycles at c=4, idx=3.
  - Response: outputs are zero, with no frame_done.
  - Response: on resume, c continues 5,6,7, then the wrap with its frame_done pulse.
- Async reset:
  - Stimulus: pull rst_n low mid-DRIVE with pending=1.
  - Response: seg_out=0 and dig_sel=0 immediately, with no clock edge needed.
  - Response: after release, disp=0 and the pending data is never displayed.

Source files
------------

// File: rtl/seg_scan_driver.sv
// Multiplexed seven-segment scanner: one-hot digit enables on a shared segment bus, with
// frame-synchronous double buffering, per-slot dead-time blanking and per-digit blinking.
module seg_scan_driver #(
  parameter int unsigned NUM_DIGITS   = 4,
  parameter int unsigned SCAN_DIV     = 1000,
  parameter int unsigned BLANK_CYCLES = 16,
  parameter int unsigned BLINK_FRAMES = 64
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    scan_en_i,
  input  logic [8*NUM_DIGITS-1:0] digits_in_i,
  input  logic                    load_i,
  input  logic [NUM_DIGITS-1:0]   blink_mask_i,
  output logic [7:0]              seg_out_o,
  output logic [NUM_DIGITS-1:0]   dig_sel_o,
  output logic                    frame_done_o
);

  localparam int unsigned CW = $clog2(SCAN_DIV);
  localparam int unsigned IW = $clog2(NUM_DIGITS);
  localparam int unsigned FW = $clog2(2 * BLINK_FRAMES);

  localparam logic [CW-1:0] CMax    = CW'(SCAN_DIV - 1);
  localparam logic [IW-1:0] IdxMax  = IW'(NUM_DIGITS - 1);
  localparam logic [FW-1:0] FMax    = FW'(2 * BLINK_FRAMES - 1);
  localparam logic [CW-1:0] CBlank  = CW'(BLANK_CYCLES);
  localparam logic [FW-1:0] FBlinkO = FW'(BLINK_FRAMES);

  logic [CW-1:0]                c_q, c_d;
  logic [IW-1:0]                idx_q, idx_d;
  logic [FW-1:0]                f_q, f_d;
  logic [NUM_DIGITS-1:0][7:0]   buf_q, buf_d;
  logic [NUM_DIGITS-1:0][7:0]   disp_q, disp_d;
  logic                         pend_q, pend_d;
  logic [7:0]                   seg_q, seg_d;
  logic [NUM_DIGITS-1:0]        sel_q, sel_d;
  logic                         fd_q, fd_d;
  logic                         wrap;

  always_comb begin
    c_d    = c_q;
    idx_d  = idx_q;
    f_d    = f_q;
    buf_d  = buf_q;
    disp_d = disp_q;
    pend_d = pend_q;
    seg_d  = '0;
    sel_d  = '0;
    fd_d   = 1'b0;

    wrap = scan_en_i && (c_q == CMax) && (idx_q == IdxMax);

    if (scan_en_i) begin
      if (c_q == CMax) begin
        c_d   = '0;
        idx_d = (idx_q == IdxMax) ? '0 : idx_q + 1'b1;
      end else begin
        c_d = c_q + 1'b1;
      end
    end

    // disp only changes on the frame wrap; a load on that very edge bypasses the shadow buffer
    if (wrap) begin
      if (load_i) begin
        disp_d = digits_in_i;
        buf_d  = digits_in_i;
      end else if (pend_q) begin
        disp_d = buf_q;
      end
      pend_d = 1'b0;
      f_d    = (f_q == FMax) ? '0 : f_q + 1'b1;
      fd_d   = 1'b1;
    end else if (load_i) begin
      buf_d  = digits_in_i;
      pend_d = 1'b1;
    end

    // Outputs are computed from next-state so they stay coherent with c and idx
    if (scan_en_i && (c_d >= CBlank)) begin
      sel_d = NUM_DIGITS'(1) << idx_d;
      if (!(blink_mask_i[idx_d] && (f_d >= FBlinkO))) begin
        seg_d = disp_d[idx_d];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      c_q    <= '0;
      idx_q  <= '0;
      f_q    <= '0;
      buf_q  <= '0;
      disp_q <= '0;
      pend_q <= 1'b0;
      seg_q  <= '0;
      sel_q  <= '0;
      fd_q   <= 1'b0;
    end else begin
      c_q    <= c_d;
      idx_q  <= idx_d;
      f_q    <= f_d;
      buf_q  <= buf_d;
      disp_q <= disp_d;
      pend_q <= pend_d;
      seg_q  <= seg_d;
      sel_q  <= sel_d;
      fd_q   <= fd_d;
    end
  end

  assign seg_out_o    = seg_q;
  assign dig_sel_o    = sel_q;
  assign frame_done_o = fd_q;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Scoreboard bench for seg_scan_driver: a timeline model derives expected outputs from the
// count of enabled edges since reset; a negedge monitor pops and compares every cycle.
module tb_seg_scan_driver;

  localparam int ND    = 4;
  localparam int SD    = 8;
  localparam int BC    = 2;
  localparam int BF    = 2;
  localparam int FRAME = ND * SD;

  logic            clk     = 1'b0;
  logic            rst_n   = 1'b0;
  logic            scan_en = 1'b0;
  logic            load    = 1'b0;
  logic [8*ND-1:0] din     = '0;
  logic [ND-1:0]   bmask   = '0;
  logic [7:0]      seg_w;
  logic [ND-1:0]   sel_w;
  logic            fd_w;

  typedef struct packed {
    logic [7:0]    seg;
    logic [ND-1:0] sel;
    logic          fd;
  } exp_t;

  exp_t expq[$];
  int   n_pass = 0;
  int   n_total = 0;
  int   n_prn = 0;

  // Reference model state: enabled-edge count since reset, displayed/shadow words, pending
  int              m_n;
  logic [8*ND-1:0] m_disp;
  logic [8*ND-1:0] m_buf;
  logic            m_pend;
  int              m_c, m_idx, m_f;
  logic            m_wrap;
  exp_t            m_e;
  exp_t            mon_e;
  exp_t            mon_got;

  seg_scan_driver #(
    .NUM_DIGITS  (ND),
    .SCAN_DIV    (SD),
    .BLANK_CYCLES(BC),
    .BLINK_FRAMES(BF)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .scan_en_i   (scan_en),
    .digits_in_i (din),
    .load_i      (load),
    .blink_mask_i(bmask),
    .seg_out_o   (seg_w),
    .dig_sel_o   (sel_w),
    .frame_done_o(fd_w)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input exp_t got, input exp_t want);
    n_total++;
    if (got === want) begin
      n_pass++;
    end else if (n_prn < 40) begin
      n_prn++;
      $display("FAIL %s t=%0t got seg=%h sel=%b fd=%b want seg=%h sel=%b fd=%b",
               name, $time, got.seg, got.sel, got.fd, want.seg, want.sel, want.fd);
    end
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_n    = 0;
      m_disp = '0;
      m_buf  = '0;
      m_pend = 1'b0;
      expq.delete();
    end else begin
      m_wrap = 1'b0;
      if (scan_en) begin
        m_n++;
        m_wrap = ((m_n % FRAME) == 0);
      end
      if (m_wrap) begin
        if (load) begin
          m_disp = din;
          m_buf  = din;
        end else if (m_pend) begin
          m_disp = m_buf;
        end
        m_pend = 1'b0;
      end else if (load) begin
        m_buf  = din;
        m_pend = 1'b1;
      end
      m_c   = m_n % SD;
      m_idx = (m_n / SD) % ND;
      m_f   = (m_n / FRAME) % (2 * BF);
      m_e    = '0;
      m_e.fd = m_wrap;
      if (scan_en && m_c >= BC) begin
        m_e.sel = ND'(1) << m_idx;
        m_e.seg = (bmask[m_idx] && m_f >= BF) ? 8'h00 : m_disp[m_idx*8 +: 8];
      end
      expq.push_back(m_e);
    end
  end

  always @(negedge clk) begin
    mon_got = {seg_w, sel_w, fd_w};
    if (!rst_n) begin
      check("reset_hold", mon_got, '0);
    end else if (expq.size() > 0) begin
      mon_e = expq.pop_front();
      check("scan", mon_got, mon_e);
    end
  end

  task automatic cyc(input int k);
    repeat (k) begin
      @(posedge clk);
      #2;
    end
  endtask

  // Advance until the model's enabled-edge count hits the requested phase
  task automatic wait_phase(input int modv, input int target, input string name);
    int i;
    for (i = 0; i < 400; i++) begin
      if ((m_n % modv) == target) break;
      cyc(1);
    end
    if (i == 400) begin
      n_total++;
      $display("FAIL timeout %s t=%0t got phase=%0d want phase=%0d", name, $time,
               m_n % modv, target);
    end
  endtask

  initial begin
    cyc(3);
    @(negedge clk);
    #1;
    rst_n   = 1'b1;
    scan_en = 1'b1;

    // Load on the first frame wrap, then watch a full frame of scanning
    wait_phase(FRAME, FRAME - 1, "first_wrap");
    din  = 32'hFC_60_DA_F2;
    load = 1'b1;
    cyc(1);
    load = 1'b0;
    cyc(FRAME + 2);

    // Mid-frame load while digit 1 is being driven
    wait_phase(FRAME, SD + 2, "mid_frame");
    din  = 32'h11111111;
    load = 1'b1;
    cyc(1);
    load = 1'b0;
    din  = $urandom;
    cyc(FRAME + 4);

    // Load coincident with the wrap edge
    wait_phase(FRAME, FRAME - 1, "wrap_load");
    din  = 32'hA5_3C_7E_81;
    load = 1'b1;
    cyc(1);
    load = 1'b0;
    cyc(FRAME);

    // Blink digit 2 across a full blink period
    bmask = 4'b0100;
    cyc(4 * FRAME + 3);
    bmask = '0;

    // Pause scanning at c=4, idx=3 for five edges
    wait_phase(FRAME, 28, "scan_pause");
    scan_en = 1'b0;
    cyc(5);
    scan_en = 1'b1;
    cyc(FRAME);

    // Async reset mid-DRIVE with a pending load
    wait_phase(FRAME, 5, "pre_reset_load");
    din  = 32'hDE_AD_BE_EF;
    load = 1'b1;
    cyc(1);
    load = 1'b0;
    wait_phase(FRAME, 12, "reset_point");
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    mon_got = {seg_w, sel_w, fd_w};
    check("async_reset", mon_got, '0);
    cyc(3);
    @(negedge clk);
    #1;
    rst_n = 1'b1;
    cyc(3 * FRAME);

    // Randomized traffic: loads, blink masks and scan_en drops
    for (int i = 0; i < 1500; i++) begin
      load    = ($urandom_range(0, 15) == 0);
      din     = $urandom;
      scan_en = ($urandom_range(0, 19) != 0);
      if ($urandom_range(0, 63) == 0) bmask = ND'($urandom);
      if ((m_n % FRAME) == FRAME - 1 && $urandom_range(0, 3) == 0) load = 1'b1;
      cyc(1);
    end
    load    = 1'b0;
    scan_en = 1'b1;
    cyc(2 * FRAME);

    @(negedge clk);
    #1;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
